pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter stage fed by the <<2 branch-offset shifter. Owns the PC register.
//  Selects each cycle between sequential fetch (PC+4), branch target, J-type jump and JR.
//  Branch target = branch_pc_plus4 + branch_offset. branch_offset is already <<2.
//  Holds a redirect that arrives during a stall and applies it once the stall drops.
//  Emits a one-cycle flush pulse for the fetch/decode stages.
// PARAMETERS
//  WIDTH     32            address width; sums wrap modulo 2**WIDTH
//  RESET_PC  32'hBFC0_0000 PC value loaded on reset
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  rst              in   1      synchronous, active-high reset
//  stall            in   1      hazard unit freezes the PC
//  branch_taken     in   1      resolved conditional branch is taken
//  branch_pc_plus4  in   WIDTH  PC+4 of the branch/jump instruction
//  branch_offset    in   WIDTH  sign-extended immediate, already shifted <<2
//  jump             in   1      J/JAL in decode
//  jump_index       in   26     instr[25:0]
//  jr               in   1      JR/JALR in decode
//  jr_addr          in   WIDTH  register-sourced target
//  pc               out  WIDTH  current fetch address
//  pc_plus4         out  WIDTH  pc + 4, combinational
//  flush            out  1      redirect was applied on the previous edge
//  misalign         out  1      only with PC_MISALIGN_CHK_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset values
//   - pc=RESET_PC, flush=0, misalign=0, state=RUN, pending target cleared.
//   - A reset mid-redirect or mid-pending discards everything.
//  Redirect request: req = jr | jump | branch_taken.
//   - Priority: jr > jump > branch_taken.
//  Targets
//   - jr:     jr_addr
//   - jump:   {branch_pc_plus4[WIDTH-1:28], jump_index, 2'b00}
//   - branch: branch_pc_plus4 + branch_offset. WIDTH-bit add, carry dropped.
//     Backward offsets wrap correctly.
//  FSM state RUN
//   - stall=0, req=0: pc <= pc+4. 32'hFFFF_FFFC wraps to 0.
//   - stall=0, req=1: pc <= target; flush=1 next cycle. One-edge latency.
//   - stall=1, req=0: pc holds.
//   - stall=1, req=1: pc holds; target latched in pend_q; go to PEND.
//  FSM state PEND
//   - stall=1: pc holds; new req ignored. The older redirect wins.
//   - stall=0: pc <= pend_q; flush=1 next cycle; go to RUN.
//     req in this same cycle is ignored, since its source is flushed.
//  flush
//   - Registered and high for exactly one cycle per applied redirect.
//   - Back-to-back redirects in RUN give consecutive flush cycles.
//  pc_plus4 is always pc+4, including while stalled.
// CONFIGURATION
//  PC_MISALIGN_CHK_EN defined
//   - A selected jr target with [1:0]!=0 is not loaded; pc holds.
//   - misalign=1 for one cycle on the next edge; flush stays 0.
//   - Same check applies to a pending jr target in PEND.
//  PC_MISALIGN_CHK_EN undefined
//   - jr target is loaded with [1:0] forced to 2'b00.
//   - misalign port is tied to 0.
// TESTING
//  1. rst=1 for 2 cycles, then run 3 cycles -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; flush=0.
//  2. branch_taken, branch_pc_plus4=00400010, branch_offset=FFFFFFF0 (-4<<2) -> pc=00400000 next edge; flush=1 for 1 cycle.
//  3. jr and jump both high, jr_addr=00401000, jump_index=0000100 -> pc=00401000 (jr wins).
//  4. stall=1 with jump (index 3FFFFFF, pc_plus4 top=0) for 3 cycles, then stall=0 -> pc holds, then 0FFFFFFC; flush pulse after release.
//  5. Two redirects in PEND, then rst asserted mid-PEND -> first target kept; after rst, pc=RESET_PC and no flush.
//  6. jr_addr=00400002 -> with _EN: pc holds, misalign=1 for 1 cycle; without: pc=00400000, flush=1.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// Bus between the PC stage and its neighbours: redirect requests in, fetch address and status out.
interface pc_next_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_pc_plus4;
  logic [WIDTH-1:0] branch_offset;
  logic             jump;
  logic [25:0]      jump_index;
  logic             jr;
  logic [WIDTH-1:0] jr_addr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             flush;
  logic             misalign;

  modport master (
    output stall, branch_taken, branch_pc_plus4, branch_offset,
           jump, jump_index, jr, jr_addr,
    input  pc, pc_plus4, flush, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_pc_plus4, branch_offset,
           jump, jump_index, jr, jr_addr,
    output pc, pc_plus4, flush, misalign
  );
endinterface

// File: rtl/pc_next_unit.sv
// PC register with branch/jump/JR redirect, stall-deferred redirects and a one-cycle flush pulse.
// Optional macro PC_MISALIGN_CHK_EN: reject misaligned JR targets and report them on misalign.
module pc_next_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input logic          clk,
  input logic          rst,
  pc_next_unit_if.slave bus
);

  typedef enum logic [0:0] {RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             flush_q, flush_d;
  logic             req;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] target;

`ifdef PC_MISALIGN_CHK_EN
  logic pend_jr_q, pend_jr_d;
  logic misalign_q;
  logic reject;
  logic target_bad;
  logic pend_bad;

  assign jr_target  = bus.jr_addr;
  assign target_bad = bus.jr && (bus.jr_addr[1:0] != 2'b00);
  assign pend_bad   = pend_jr_q && (pend_q[1:0] != 2'b00);
`else
  assign jr_target  = bus.jr_addr & ~WIDTH'(3);
`endif

  assign req = bus.jr | bus.jump | bus.branch_taken;

  always_comb begin
    target = bus.branch_pc_plus4 + bus.branch_offset;
    if (bus.jr) begin
      target = jr_target;
    end else if (bus.jump) begin
      target = {bus.branch_pc_plus4[WIDTH-1:28], bus.jump_index, 2'b00};
    end
  end

  // A redirect seen in PEND is dropped: the older one wins, and any request
  // arriving on the release cycle comes from an instruction being flushed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
    pend_jr_d = pend_jr_q;
    reject    = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (req) begin
`ifdef PC_MISALIGN_CHK_EN
            if (target_bad) begin
              reject = 1'b1;
            end else begin
              pc_d    = target;
              flush_d = 1'b1;
            end
`else
            pc_d    = target;
            flush_d = 1'b1;
`endif
          end else begin
            pc_d = pc_q + WIDTH'(4);
          end
        end else if (req) begin
          pend_d  = target;
          state_d = PEND;
`ifdef PC_MISALIGN_CHK_EN
          pend_jr_d = bus.jr;
`endif
        end
      end
      PEND: begin
        if (!bus.stall) begin
          state_d = RUN;
`ifdef PC_MISALIGN_CHK_EN
          if (pend_bad) begin
            reject = 1'b1;
          end else begin
            pc_d    = pend_q;
            flush_d = 1'b1;
          end
`else
          pc_d    = pend_q;
          flush_d = 1'b1;
`endif
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_jr_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pend_jr_q  <= pend_jr_d;
      misalign_q <= reject;
    end
  end

  assign bus.misalign = misalign_q;
`else
  assign bus.misalign = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + WIDTH'(4);
  assign bus.flush    = flush_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a queue-based redirect model checked every cycle plus literal pins.
module tb_pc_next_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_next_unit_if #(.WIDTH(32)) bus ();

  pc_next_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: a redirect is an address plus whether it came from JR; deferred ones wait in a queue.
  typedef struct {
    logic [31:0] addr;
    bit          is_jr;
  } redirect_t;

  redirect_t   pending[$];
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_mis;
  bit          model_ready = 1'b0;

  function automatic redirect_t chooseRedirect();
    redirect_t r;
    r.is_jr = bus.jr;
    if (bus.jr)        r.addr = bus.jr_addr;
    else if (bus.jump) r.addr = {bus.branch_pc_plus4[31:28], bus.jump_index, 2'b00};
    else               r.addr = bus.branch_pc_plus4 + bus.branch_offset;
    return r;
  endfunction

  task automatic takeRedirect(input redirect_t r);
`ifdef PC_MISALIGN_CHK_EN
    if (r.is_jr && r.addr[1:0] != 2'b00) begin
      m_mis = 1'b1;
      return;
    end
    m_pc = r.addr;
`else
    m_pc = r.is_jr ? {r.addr[31:2], 2'b00} : r.addr;
`endif
    m_flush = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc        = RESET_PC;
      m_flush     = 1'b0;
      m_mis       = 1'b0;
      pending.delete();
      model_ready = 1'b1;
    end else if (model_ready) begin
      m_flush = 1'b0;
      m_mis   = 1'b0;
      if (pending.size() != 0) begin
        if (!bus.stall) takeRedirect(pending.pop_front());
      end else if (bus.jr || bus.jump || bus.branch_taken) begin
        if (bus.stall) pending.push_back(chooseRedirect());
        else           takeRedirect(chooseRedirect());
      end else if (!bus.stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("model pc", bus.pc, m_pc);
      checkOutput("model pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      checkOutput("model flush", {31'b0, bus.flush}, {31'b0, m_flush});
      checkOutput("model misalign", {31'b0, bus.misalign}, {31'b0, m_mis});
    end
  end

  task automatic applyStimulus(input bit s, input bit br, input logic [31:0] pc4,
                               input logic [31:0] off, input bit j, input logic [25:0] idx,
                               input bit r, input logic [31:0] ja);
    bus.stall           = s;
    bus.branch_taken    = br;
    bus.branch_pc_plus4 = pc4;
    bus.branch_offset   = off;
    bus.jump            = j;
    bus.jump_index      = idx;
    bus.jr              = r;
    bus.jr_addr         = ja;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic expectLit(input string tag, input logic [31:0] p, input bit f, input bit m);
    checkOutput({tag, " pc"}, bus.pc, p);
    checkOutput({tag, " flush"}, {31'b0, bus.flush}, {31'b0, f});
    checkOutput({tag, " misalign"}, {31'b0, bus.misalign}, {31'b0, m});
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_pc_plus4 = '0; bus.branch_offset = '0;
    bus.jump = 0; bus.jump_index = '0; bus.jr = 0; bus.jr_addr = '0;
    @(negedge clk);
    @(negedge clk);
    expectLit("reset", 32'hBFC0_0000, 0, 0);
    rst = 1'b0;

    idle(); expectLit("seq1", 32'hBFC0_0004, 0, 0);
    idle(); expectLit("seq2", 32'hBFC0_0008, 0, 0);
    idle(); expectLit("seq3", 32'hBFC0_000C, 0, 0);

    // backward branch
    applyStimulus(0, 1, 32'h0040_0010, 32'hFFFF_FFF0, 0, 26'h0, 0, 32'h0);
    expectLit("branch back", 32'h0040_0000, 1, 0);
    idle(); expectLit("after branch", 32'h0040_0004, 0, 0);

    // jr beats jump
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 26'h0000100, 1, 32'h0040_1000);
    expectLit("jr wins", 32'h0040_1000, 1, 0);
    idle(); expectLit("after jr", 32'h0040_1004, 0, 0);

    // jump while stalled, released with a branch that must be ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h0, 32'h0, 1, 26'h3FFFFFF, 0, 32'h0);
      expectLit("stall hold", 32'h0040_1004, 0, 0);
    end
    applyStimulus(0, 1, 32'h0050_0000, 32'h0, 0, 26'h0, 0, 32'h0);
    expectLit("stall release", 32'h0FFF_FFFC, 1, 0);
    idle(); expectLit("after release", 32'h1000_0000, 0, 0);

    // back-to-back redirects, branch sum with dropped carry
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_1000);
    expectLit("b2b first", 32'h0040_1000, 1, 0);
    applyStimulus(0, 1, 32'hFFFF_FFF0, 32'h0000_0020, 0, 26'h0, 0, 32'h0);
    expectLit("b2b second", 32'h0000_0010, 1, 0);
    idle(); expectLit("after b2b", 32'h0000_0014, 0, 0);

    // sequential wrap
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
    expectLit("to top", 32'hFFFF_FFFC, 1, 0);
    idle(); expectLit("wrap", 32'h0000_0000, 0, 0);

    // second redirect in PEND ignored, first one applied on release
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 26'h0000040, 0, 32'h0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_2000);
    expectLit("pend hold", 32'h0000_0000, 0, 0);
    idle(); expectLit("older wins", 32'h0000_0100, 1, 0);
    idle(); expectLit("after pend", 32'h0000_0104, 0, 0);

    // reset mid-PEND discards the pending target
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 26'h0000040, 0, 32'h0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_2000);
    rst = 1'b1;
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 26'h0, 0, 32'h0);
    expectLit("rst in pend", 32'hBFC0_0000, 0, 0);
    rst = 1'b0;
    idle(); expectLit("pend dropped", 32'hBFC0_0004, 0, 0);

    // misaligned jr, direct then deferred
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_0002);
`ifdef PC_MISALIGN_CHK_EN
    expectLit("jr misaligned", 32'hBFC0_0004, 0, 1);
    idle(); expectLit("after misalign", 32'hBFC0_0008, 0, 0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_0003);
    idle(); expectLit("pend misaligned", 32'hBFC0_0008, 0, 1);
`else
    expectLit("jr misaligned", 32'h0040_0000, 1, 0);
    idle(); expectLit("after misalign", 32'h0040_0004, 0, 0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0040_0003);
    idle(); expectLit("pend misaligned", 32'h0040_0000, 1, 0);
`endif
    idle();
    idle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
